// File: rtl/quad_step_emitter_pkg.sv
// Shared definitions for the quadrature step emitter: Gray map, direction
// constants and FSM state encodings.
package quad_step_emitter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // {a,b} line levels for a Gray index
  function automatic logic [1:0] gray_ab(input logic [1:0] q);
    logic [1:0] ab;
    case (q)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  function automatic logic [1:0] gray_step(input logic [1:0] q, input logic dir);
    if (dir == DIR_CW) return q + 2'd1;
    return q - 2'd1;
  endfunction

endpackage

// File: rtl/prbs_lfsr8.sv
// 8-bit Fibonacci PRBS (x^8+x^6+x^5+x^4+1) used as the contact-bounce source.
module prbs_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] state_o,
  output logic [7:0] next_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;
  assign next_o  = lfsr_d;

endmodule

// File: rtl/quad_step_emitter.sv
// Quadrature A/B generator emulating a rotary encoder; one Gray transition per
// accepted step, with optional PRBS contact bounce on the changing line.
module quad_step_emitter
  import quad_step_emitter_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES  = 64,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_valid,
  input  logic       step_dir,
  output logic       step_ready,
  input  logic       bounce_en,
  output logic       quad_a,
  output logic       quad_b,
  output logic       busy,
  output logic [7:0] position
);

  localparam int unsigned MAX_CYC = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gq_q, gq_d;
  logic [7:0]       pos_q, pos_d;
  logic [1:0]       chg_q, chg_d;
  logic [1:0]       ab_q, ab_d;
  logic             busy_q, busy_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             accept;
  logic             unused_lfsr;

  prbs_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .state_o (lfsr_q),
    .next_o  (lfsr_d)
  );

  assign unused_lfsr = ^{lfsr_q, lfsr_d[7:1]};

  assign step_ready = (state_q == ST_IDLE) & ~reset;
  assign accept     = step_valid & step_ready;

  // Next state; line levels are computed for the cycle they will be shown in
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gq_d    = gq_q;
    pos_d   = pos_q;
    chg_d   = chg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gq_d  = gray_step(gq_q, step_dir);
          pos_d = (step_dir == DIR_CCW) ? pos_q - 8'd1 : pos_q + 8'd1;
          chg_d = gray_ab(gq_d) ^ gray_ab(gq_q);
          if (bounce_en) begin
            state_d = ST_BOUNCE;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = PHASE_LOAD;
          end
        end
      end
      ST_BOUNCE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = PHASE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // The last bounce cycle already shows the clean new Gray code
    ab_d = gray_ab(gq_d);
    if ((state_d == ST_BOUNCE) && (cnt_d != '0)) begin
      ab_d = (ab_d & ~chg_d) | (chg_d & {2{lfsr_d[0]}});
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gq_q    <= 2'd0;
      pos_q   <= 8'd0;
      chg_q   <= 2'b00;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gq_q    <= gq_d;
      pos_q   <= pos_d;
      chg_q   <= chg_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
    end
  end

  assign quad_a   = ab_q[1];
  assign quad_b   = ab_q[0];
  assign busy     = busy_q;
  assign position = pos_q;

endmodule
